// File: rtl/cache_replace_plru_if.sv
// Access-side bundle between the cache controller and the PLRU replacement engine.
// The controller drives index/valid/match/strobes; the engine returns victim and hit info.
interface cache_replace_plru_if #(
    parameter int WAYS       = 4,
    parameter int INDEX_SIZE = 9
);
    localparam int WAY_BITS = $clog2(WAYS);

    logic [INDEX_SIZE-1:0] index;
    logic [WAYS-1:0]       valid;
    logic [WAYS-1:0]       match;
    logic                  rd_hit;
    logic                  fill;
    logic [WAY_BITS-1:0]   victim;
    logic                  hit;
    logic [WAY_BITS-1:0]   hit_way;
    logic                  multi_hit;

    modport master (
        output index, valid, match, rd_hit, fill,
        input  victim, hit, hit_way, multi_hit
    );

    modport slave (
        input  index, valid, match, rd_hit, fill,
        output victim, hit, hit_way, multi_hit
    );
endinterface

// File: rtl/cache_replace_plru.sv
// Tree pseudo-LRU replacement engine for an N-way set-associative cache with a
// one-stage pending-touch register and same-index bypass. Optional counters: CACHE_REPLACE_STATS_EN.
module cache_replace_plru #(
    parameter int WAYS       = 4,
    parameter int INDEX_SIZE = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    cache_replace_plru_if.slave  bus
`ifdef CACHE_REPLACE_STATS_EN
    ,
    input  logic                 stats_clr,
    output logic [31:0]          hit_cnt,
    output logic [31:0]          miss_cnt
`endif
);
    localparam int SETS     = 1 << INDEX_SIZE;
    localparam int WAY_BITS = $clog2(WAYS);
    localparam int NODES    = WAYS - 1;

    typedef logic [NODES-1:0]    tree_t;
    typedef logic [WAY_BITS-1:0] way_t;

    // Lowest-numbered set bit of a way vector; 0 when the vector is empty.
    function automatic way_t lowest_set(input logic [WAYS-1:0] vec);
        way_t w;
        w = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                w = way_t'(i);
            end
        end
        return w;
    endfunction

    // True when more than one bit is set (clearing the lowest set bit leaves something).
    function automatic logic more_than_one(input logic [WAYS-1:0] vec);
        logic [WAYS-1:0] one;
        one = {{(WAYS-1){1'b0}}, 1'b1};
        return (vec & (vec - one)) != {WAYS{1'b0}};
    endfunction

    // Point every node on the way's root-to-leaf path away from that way.
    function automatic tree_t touch(input tree_t t, input way_t w);
        tree_t r;
        int    node;
        logic  upper;
        r    = t;
        node = 0;
        for (int l = 0; l < WAY_BITS; l++) begin
            upper   = w[WAY_BITS-1-l];
            r[node] = ~upper;
            node    = 2 * node + (upper ? 2 : 1);
        end
        return r;
    endfunction

    // Follow the node bits from the root down to a leaf.
    function automatic way_t walk(input tree_t t);
        way_t w;
        int   node;
        w    = '0;
        node = 0;
        for (int l = 0; l < WAY_BITS; l++) begin
            w[WAY_BITS-1-l] = t[node];
            node            = 2 * node + (t[node] ? 2 : 1);
        end
        return w;
    endfunction

    tree_t                 tree_r [SETS];
    logic                  upd_v_r;
    logic [INDEX_SIZE-1:0] upd_idx_r;
    way_t                  upd_way_r;

    logic [WAYS-1:0]       hit_vec_s;
    logic                  hit_s;
    logic                  multi_hit_s;
    way_t                  hit_way_s;
    tree_t                 eff_s;
    way_t                  victim_s;
    way_t                  target_s;
    logic                  trig_s;

    // Hit decode, bypassed effective state, victim choice and update request.
    always_comb begin
        hit_vec_s   = bus.valid & bus.match;
        hit_s       = |hit_vec_s;
        multi_hit_s = more_than_one(hit_vec_s);
        hit_way_s   = lowest_set(hit_vec_s);
        eff_s       = tree_r[bus.index];
        victim_s    = '0;
        target_s    = '0;
        trig_s      = 1'b0;

        if (upd_v_r && (upd_idx_r == bus.index)) begin
            eff_s = touch(tree_r[bus.index], upd_way_r);
        end else begin
            eff_s = tree_r[bus.index];
        end

        // Invalid ways are always filled first; the tree only arbitrates a full set.
        if (&bus.valid) begin
            victim_s = walk(eff_s);
        end else begin
            victim_s = lowest_set(~bus.valid);
        end

        // A hit always names the way; only a missing fill falls back to the victim.
        if (hit_s) begin
            target_s = hit_way_s;
        end else begin
            target_s = victim_s;
        end

        if ((bus.fill || (bus.rd_hit && hit_s)) && !multi_hit_s) begin
            trig_s = 1'b1;
        end else begin
            trig_s = 1'b0;
        end
    end

    assign bus.hit       = hit_s;
    assign bus.hit_way   = hit_way_s;
    assign bus.multi_hit = multi_hit_s;
    assign bus.victim    = victim_s;

    // Pending-touch register: captures the current request every edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd_v_r   <= 1'b0;
            upd_idx_r <= '0;
            upd_way_r <= '0;
        end else begin
            upd_v_r   <= trig_s;
            upd_idx_r <= bus.index;
            upd_way_r <= target_s;
        end
    end

    // State array: commits the pending touch one edge after capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                tree_r[s] <= '0;
            end
        end else if (upd_v_r) begin
            tree_r[upd_idx_r] <= touch(tree_r[upd_idx_r], upd_way_r);
        end
    end

`ifdef CACHE_REPLACE_STATS_EN
    // Saturating hit/miss counters; clear wins over any increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= 32'd0;
            miss_cnt <= 32'd0;
        end else if (stats_clr) begin
            hit_cnt  <= 32'd0;
            miss_cnt <= 32'd0;
        end else begin
            if (trig_s && hit_s && (hit_cnt != 32'hFFFF_FFFF)) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (bus.fill && !hit_s && (miss_cnt != 32'hFFFF_FFFF)) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_replace_plru.sv
// Directed plus randomized bench for cache_replace_plru (WAYS=4) against a
// range-walking pseudo-LRU model with immediate-visibility touches.
module tb_cache_replace_plru;
    localparam int WAYS = 4;
    localparam int IDX  = 9;
    localparam int SETS = 1 << IDX;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    cache_replace_plru_if #(.WAYS(WAYS), .INDEX_SIZE(IDX)) bus ();

`ifdef CACHE_REPLACE_STATS_EN
    logic        stats_clr;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
    longint      m_hit_cnt;
    longint      m_miss_cnt;
`endif

    cache_replace_plru #(.WAYS(WAYS), .INDEX_SIZE(IDX)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus)
`ifdef CACHE_REPLACE_STATS_EN
        ,
        .stats_clr(stats_clr),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: each node covers a contiguous way range; bit=1 means "go to upper half".
    bit m_tree [SETS][WAYS-1];

    function automatic void m_reset();
        for (int s = 0; s < SETS; s++)
            for (int n = 0; n < WAYS - 1; n++)
                m_tree[s][n] = 1'b0;
`ifdef CACHE_REPLACE_STATS_EN
        m_hit_cnt  = 0;
        m_miss_cnt = 0;
`endif
    endfunction

    function automatic int m_walk(input int idx);
        int lo = 0, size = WAYS, node = 0, half;
        while (size > 1) begin
            half = size / 2;
            if (m_tree[idx][node]) begin
                lo   = lo + half;
                node = 2 * node + 2;
            end else begin
                node = 2 * node + 1;
            end
            size = half;
        end
        return lo;
    endfunction

    function automatic void m_touch(input int idx, input int w);
        int lo = 0, size = WAYS, node = 0, half;
        while (size > 1) begin
            half = size / 2;
            if (w >= lo + half) begin
                m_tree[idx][node] = 1'b0;
                lo   = lo + half;
                node = 2 * node + 2;
            end else begin
                m_tree[idx][node] = 1'b1;
                node = 2 * node + 1;
            end
            size = half;
        end
    endfunction

    function automatic int m_victim(input int idx, input logic [3:0] v);
        for (int i = 0; i < WAYS; i++)
            if (!v[i]) return i;
        return m_walk(idx);
    endfunction

    function automatic int m_hit_way(input logic [3:0] hv);
        for (int i = 0; i < WAYS; i++)
            if (hv[i]) return i;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int idx, input logic [3:0] v, input logic [3:0] m,
                         input logic rh, input logic fl);
        @(negedge clk);
        bus.index  = IDX'(idx);
        bus.valid  = v;
        bus.match  = m;
        bus.rd_hit = rh;
        bus.fill   = fl;
        #1;
    endtask

    // Compare all combinational outputs with the model for the currently driven inputs.
    task automatic check_all(input string tag);
        logic [3:0] hv;
        hv = bus.valid & bus.match;
        chk({tag, "_hit"},       64'(bus.hit),       64'(hv != 4'd0));
        chk({tag, "_hit_way"},   64'(bus.hit_way),   64'(m_hit_way(hv)));
        chk({tag, "_multi_hit"}, 64'(bus.multi_hit), 64'($countones(hv) > 1));
        chk({tag, "_victim"},    64'(bus.victim),    64'(m_victim(int'(bus.index), bus.valid)));
    endtask

    // Advance one edge and apply the request the DUT captures on it.
    task automatic tick();
        logic [3:0] hv;
        bit         h, mh, trig;
        int         idx, tgt;
        hv   = bus.valid & bus.match;
        h    = (hv != 4'd0);
        mh   = ($countones(hv) > 1);
        idx  = int'(bus.index);
        tgt  = h ? m_hit_way(hv) : m_victim(idx, bus.valid);
        trig = (bus.fill || (bus.rd_hit && h)) && !mh;
        @(posedge clk);
        if (trig) m_touch(idx, tgt);
`ifdef CACHE_REPLACE_STATS_EN
        if (stats_clr) begin
            m_hit_cnt  = 0;
            m_miss_cnt = 0;
        end else begin
            if (trig && h && m_hit_cnt < 64'hFFFF_FFFF) m_hit_cnt++;
            if (bus.fill && !h && m_miss_cnt < 64'hFFFF_FFFF) m_miss_cnt++;
        end
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        m_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int exp_seq [5];
        exp_seq = '{0, 2, 1, 3, 0};
        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus.index = '0; bus.valid = 4'hF; bus.match = 4'h0;
        bus.rd_hit = 1'b0; bus.fill = 1'b0;
`ifdef CACHE_REPLACE_STATS_EN
        stats_clr = 1'b0;
`endif
        m_reset();
        #12;
        do_reset();

        drive(5, 4'hF, 4'h0, 1'b0, 1'b0);
        check_all("reset");
        chk("reset_upd_v", 64'(dut.upd_v_r), 64'd0);

        for (int i = 0; i < 5; i++) begin
            drive(5, 4'hF, 4'h0, 1'b0, 1'b1);
            chk("fill_seq_victim", 64'(bus.victim), 64'(exp_seq[i]));
            tick();
        end
        drive(6, 4'hF, 4'h0, 1'b0, 1'b0);
        chk("other_set_victim", 64'(bus.victim), 64'd0);

        drive(5, 4'b1011, 4'h0, 1'b0, 1'b1);
        chk("invalid_pref_victim", 64'(bus.victim), 64'd2);
        tick();
        drive(5, 4'hF, 4'h0, 1'b0, 1'b0);
        check_all("after_invalid_fill");

        do_reset();
        drive(9, 4'hF, 4'b0100, 1'b1, 1'b0);
        chk("rdhit_hit", 64'(bus.hit), 64'd1);
        chk("rdhit_hit_way", 64'(bus.hit_way), 64'd2);
        tick();
        drive(9, 4'hF, 4'b0001, 1'b1, 1'b0);
        chk("rdhit2_victim_prev", 64'(bus.victim), 64'd0);
        tick();
        drive(9, 4'hF, 4'b0011, 1'b1, 1'b0);
        chk("rdhit0_victim", 64'(bus.victim), 64'd3);
        chk("multi_hit_flag", 64'(bus.multi_hit), 64'd1);
        chk("multi_hit_way", 64'(bus.hit_way), 64'd0);
        tick();
        drive(9, 4'hF, 4'h0, 1'b0, 1'b0);
        chk("multi_hit_no_update", 64'(bus.victim), 64'd3);

        // Pending touch at index 3 is killed by a reset pulse before its commit edge.
        drive(3, 4'hF, 4'h0, 1'b0, 1'b1);
        tick();
        #2 rst = 1'b1;
        m_reset();
        #2 rst = 1'b0;
        drive(3, 4'hF, 4'h0, 1'b0, 1'b0);
        chk("midrst_upd_v", 64'(dut.upd_v_r), 64'd0);
        chk("midrst_victim", 64'(bus.victim), 64'd0);
        tick();
        drive(3, 4'hF, 4'h0, 1'b0, 1'b0);
        chk("midrst_no_commit", 64'(bus.victim), 64'd0);

`ifdef CACHE_REPLACE_STATS_EN
        do_reset();
        chk("stats_rst_hit", 64'(hit_cnt), 64'd0);
        chk("stats_rst_miss", 64'(miss_cnt), 64'd0);
        for (int i = 0; i < 3; i++) begin
            drive(10 + i, 4'hF, 4'h0, 1'b0, 1'b1);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            drive(20, 4'hF, 4'b0001, 1'b1, 1'b0);
            tick();
        end
        drive(20, 4'hF, 4'h0, 1'b0, 1'b0);
        chk("stats_miss_cnt", 64'(miss_cnt), 64'd3);
        chk("stats_hit_cnt", 64'(hit_cnt), 64'd2);
        drive(11, 4'hF, 4'h0, 1'b0, 1'b1);
        stats_clr = 1'b1;
        tick();
        drive(11, 4'hF, 4'h0, 1'b0, 1'b0);
        stats_clr = 1'b0;
        chk("stats_clr_miss", 64'(miss_cnt), 64'd0);
        chk("stats_clr_hit", 64'(hit_cnt), 64'd0);
`endif

        // Random traffic concentrated on a few sets to exercise bypass collisions.
        for (int c = 0; c < 400; c++) begin
            int         sel;
            logic [3:0] v, m;
            v   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            sel = $urandom_range(0, 3);
            if (sel == 0)      m = 4'h0;
            else if (sel == 3) m = 4'($urandom);
            else               m = 4'b0001 << $urandom_range(0, 3);
            drive($urandom_range(0, 3), v, m, 1'($urandom), 1'($urandom));
`ifdef CACHE_REPLACE_STATS_EN
            stats_clr = ($urandom_range(0, 31) == 0);
            chk("rand_hit_cnt", 64'(hit_cnt), 64'(m_hit_cnt));
            chk("rand_miss_cnt", 64'(miss_cnt), 64'(m_miss_cnt));
`endif
            check_all("rand");
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
